line_fill_requester: RTL and testbench
======================================

# line_fill_requester

Initiator side of the cache-line memory interface. It accepts one miss transaction per request from a cache controller: an optional dirty-victim writeback followed by a line fill. It drives the memory's enable/op/address/data/op_init/op_done handshake and returns the filled line, or an error on timeout. It sits between a cache (instruction or data) and the shared `Memory` block.

## Interface
- `ADDRESS_SIZE`, 12: byte-address width.
- `CACHE_LINE_SIZE`, 128: line width in bits; LINE_BYTES = CACHE_LINE_SIZE/8, a power of two.
- `TIMEOUT_CYCLES`, 32: maximum cycles to wait for `mem_data_ready` per memory op; ≥ 1.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the cache presents a miss transaction.
- `req_ready` out 1: high only in IDLE.
- `req_wb` in 1: a writeback of the victim line must precede the fill.
- `req_fill_addr` in ADDRESS_SIZE: fill line address.
- `req_wb_addr` in ADDRESS_SIZE: victim line address.
- `req_wb_data` in CACHE_LINE_SIZE: victim line data.
- `resp_valid` out 1: one-cycle pulse; transaction finished.
- `resp_data` out CACHE_LINE_SIZE: filled line; valid with `resp_valid`.
- `resp_addr` out ADDRESS_SIZE: aligned fill address.
- `resp_error` out 1: a timeout occurred; valid with `resp_valid`.
- `mem_enable` out 1: memory operation active.
- `mem_op` out 1: 1 = write, 0 = read.
- `mem_address` out ADDRESS_SIZE: line-aligned address.
- `mem_data_in` out CACHE_LINE_SIZE: write data.
- `mem_op_init` out 1: one-cycle pulse on the first cycle of each memory op.
- `mem_op_done` out 1: one-cycle pulse acknowledging the returned data.
- `mem_data_out` in CACHE_LINE_SIZE: read data.
- `mem_data_ready` in 1: memory op complete; held by memory until it sees `mem_op_done`.

## Operation
- **Registered outputs:** all outputs are registered except `req_ready`, which is decoded from the state (`req_ready = (state == IDLE)`).
- **Address alignment:** both addresses have their low log2(LINE_BYTES) bits forced to 0 when latched. For the defaults, `0x123` becomes `0x120`.
- **States:** IDLE, WB_WAIT, WB_DRAIN, FILL_WAIT, FILL_DRAIN, RESP.
- **IDLE:**
  - On `req_valid`, latch the request and issue the first op in the same edge: `mem_enable`=1, `mem_op_init`=1, counter cleared.
  - If `req_wb`=1: `mem_op`=1, `mem_address` = wb address, `mem_data_in` = wb data; go to WB_WAIT.
  - Otherwise: `mem_op`=0, `mem_address` = fill address; go to FILL_WAIT.
- **WB_WAIT / FILL_WAIT:**
  - Hold all `mem_*` outputs stable. The counter increments each cycle.
  - On `mem_data_ready`=1: `mem_enable`=0 and `mem_op_done`=1 for one cycle.
  - In FILL_WAIT, also capture `mem_data_out` into `resp_data`.
  - Then go to WB_DRAIN or FILL_DRAIN respectively.
- **Timeout:** if the counter reaches TIMEOUT_CYCLES without `mem_data_ready`:
  - `mem_enable`=0, `mem_op_done` pulses, the error flag is set.
  - Go directly to RESP; a fill after a timed-out writeback is skipped.
  - `resp_data` is 0 on error.
- **WB_DRAIN:** wait for `mem_data_ready`=0, then issue the fill exactly as from IDLE: `mem_op`=0, op_init pulse, counter cleared, go to FILL_WAIT.
- **FILL_DRAIN:** wait for `mem_data_ready`=0, then go to RESP.
- **RESP:** `resp_valid`=1 for one cycle with `resp_addr` and `resp_error`; next state IDLE, flags cleared.
- **Requests while busy:** `req_valid` is ignored while `req_ready`=0. The request inputs are sampled only on the accepting edge.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; all other outputs 0, including `resp_data`, `mem_address` and `mem_data_in`.
- **Reset mid-operation:** outputs drop immediately and no `mem_op_done` is sent.
- **Accept to issue:** `mem_enable` rises in the cycle after the accepting edge.
- **Per-op latency:** if `mem_data_ready` is first sampled high at edge k:
  - `mem_op_done` is high in cycle k→k+1.
  - The drain sees ready low at edge k+2 at the earliest.
  - The next op's `mem_enable`, or `resp_valid`, follows at edge k+2.
- **Fill-only transaction:** `resp_valid` asserts 2 cycles after the capture edge.
- **Back-to-back:** a new request can be accepted the cycle after `resp_valid`.
- **`mem_enable` is never high while `mem_data_ready` is high** for the same op, after the capture edge.
- **Simultaneous data and timeout:** `mem_data_ready`=1 on the same edge the counter expires counts as success, with no error.
- **Counter width:** $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Test plan
- **Fill only:** reset, then request `req_fill_addr`=0x040, `req_wb`=0, against a memory model with a 5-cycle ready delay and line data 0x00112233_44556677_8899AABB_CCDDEEFF.
  - Expect one read op at 0x040 with one op_init pulse and one op_done pulse.
  - Expect `resp_valid` with that data and `resp_error`=0.
- **Writeback then fill:** `req_wb_addr`=0x1F7, data 0xA5…A5, fill addr 0x300.
  - Expect a write to 0x1F0 with 0xA5…A5, then a read at 0x300, strictly ordered, each with its own op_init and op_done.
- **Timeout:** the memory never asserts ready.
  - After TIMEOUT_CYCLES, expect `mem_enable`=0 and `resp_valid` with `resp_error`=1 and `resp_data`=0.
  - With `req_wb`=1, expect no fill op to be issued.
- **Boundary:** ready arrives exactly at TIMEOUT_CYCLES → success, `resp_error`=0.
- **Reset mid-operation:** assert `reset_n`=0 during FILL_WAIT → all outputs 0 asynchronously; the next request completes normally.
- **Busy request:** `req_valid` held high while busy with different addresses → only the first is serviced; the second is accepted the cycle after `resp_valid`.

Source files
------------

// File: rtl/line_fill_requester.sv
// line_fill_requester: initiator side of the cache-line memory interface.
// Takes one miss transaction from a cache controller (an optional dirty-victim
// writeback followed by a line fill). It runs the memory
// enable/op_init/op_done handshake and returns the filled line. If memory
// does not answer within TIMEOUT_CYCLES, it returns an error instead.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req_*               miss request from the cache (req_ready decoded from state)
//   resp_*              one-cycle response pulse with filled line / error
//   mem_*               memory handshake (enable, op, address, data, init/done pulses)
module line_fill_requester #(
  parameter int unsigned ADDRESS_SIZE    = 12,
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned TIMEOUT_CYCLES  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wb,
  input  logic [ADDRESS_SIZE-1:0]    req_fill_addr,
  input  logic [ADDRESS_SIZE-1:0]    req_wb_addr,
  input  logic [CACHE_LINE_SIZE-1:0] req_wb_data,
  output logic                       resp_valid,
  output logic [CACHE_LINE_SIZE-1:0] resp_data,
  output logic [ADDRESS_SIZE-1:0]    resp_addr,
  output logic                       resp_error,
  output logic                       mem_enable,
  output logic                       mem_op,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  output logic                       mem_op_init,
  output logic                       mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  input  logic                       mem_data_ready
);

  localparam int unsigned LINE_BYTES = CACHE_LINE_SIZE / 8;
  localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_WAIT,
    S_WB_DRAIN,
    S_FILL_WAIT,
    S_FILL_DRAIN,
    S_RESP
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [ADDRESS_SIZE-1:0]  r_fill_addr;

  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_expire;

  assign req_ready = (r_state == S_IDLE);

  // Saturating wait counter; expiry is judged on the value this edge would reach.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_expire  = (w_cnt_inc == CNT_MAX);

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fill_addr <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_addr   <= '0;
      resp_error  <= 1'b0;
      mem_enable  <= 1'b0;
      mem_op      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_op_init <= 1'b0;
      mem_op_done <= 1'b0;
    end else begin
      mem_op_init <= 1'b0;
      mem_op_done <= 1'b0;
      resp_valid  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_fill_addr <= req_fill_addr & ALIGN_MASK;
            r_cnt       <= '0;
            resp_data   <= '0;
            resp_error  <= 1'b0;
            mem_enable  <= 1'b1;
            mem_op_init <= 1'b1;
            if (req_wb) begin
              mem_op      <= 1'b1;
              mem_address <= req_wb_addr & ALIGN_MASK;
              mem_data_in <= req_wb_data;
              r_state     <= S_WB_WAIT;
            end else begin
              mem_op      <= 1'b0;
              mem_address <= req_fill_addr & ALIGN_MASK;
              mem_data_in <= '0;
              r_state     <= S_FILL_WAIT;
            end
          end
        end

        S_WB_WAIT, S_FILL_WAIT: begin
          // Ready on the expiry edge still counts as success.
          if (mem_data_ready) begin
            mem_enable  <= 1'b0;
            mem_op_done <= 1'b1;
            if (r_state == S_FILL_WAIT) begin
              resp_data <= mem_data_out;
              r_state   <= S_FILL_DRAIN;
            end else begin
              r_state   <= S_WB_DRAIN;
            end
          end else if (w_expire) begin
            // Timeout ends the whole transaction; any pending fill is skipped.
            mem_enable  <= 1'b0;
            mem_op_done <= 1'b1;
            resp_data   <= '0;
            resp_addr   <= r_fill_addr;
            resp_error  <= 1'b1;
            resp_valid  <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WB_DRAIN: begin
          if (!mem_data_ready) begin
            r_cnt       <= '0;
            mem_enable  <= 1'b1;
            mem_op_init <= 1'b1;
            mem_op      <= 1'b0;
            mem_address <= r_fill_addr;
            mem_data_in <= '0;
            r_state     <= S_FILL_WAIT;
          end
        end

        S_FILL_DRAIN: begin
          if (!mem_data_ready) begin
            resp_addr  <= r_fill_addr;
            resp_valid <= 1'b1;
            r_state    <= S_RESP;
          end
        end

        S_RESP: begin
          resp_error <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_requester.sv
// Scoreboard bench for line_fill_requester: expected memory ops and responses
// are queued by the stimulus; a negedge monitor pops and compares them.
module tb_line_fill_requester;

  localparam int unsigned AW = 12;
  localparam int unsigned LW = 128;
  localparam int unsigned TO = 32;

  typedef struct packed {
    logic          op;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } op_t;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [AW-1:0] addr;
    logic          err;
  } resp_t;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wb;
  logic [AW-1:0] req_fill_addr;
  logic [AW-1:0] req_wb_addr;
  logic [LW-1:0] req_wb_data;
  logic          resp_valid;
  logic [LW-1:0] resp_data;
  logic [AW-1:0] resp_addr;
  logic          resp_error;
  logic          mem_enable;
  logic          mem_op;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in;
  logic          mem_op_init;
  logic          mem_op_done;
  logic [LW-1:0] mem_data_out;
  logic          mem_data_ready;

  line_fill_requester #(
    .ADDRESS_SIZE   (AW),
    .CACHE_LINE_SIZE(LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wb        (req_wb),
    .req_fill_addr (req_fill_addr),
    .req_wb_addr   (req_wb_addr),
    .req_wb_data   (req_wb_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_addr     (resp_addr),
    .resp_error    (resp_error),
    .mem_enable    (mem_enable),
    .mem_op        (mem_op),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_op_init   (mem_op_init),
    .mem_op_done   (mem_op_done),
    .mem_data_out  (mem_data_out),
    .mem_data_ready(mem_data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;
  int init_cyc = 0;
  int last_resp_cyc = 0;
  int lat = 0;
  int gap = 0;

  op_t   exp_ops[$];
  resp_t exp_resp[$];

  // Memory model: delay D means ready is first sampled high D edges after the issue edge; 0 = never.
  int            mem_delay = 5;
  logic [LW-1:0] mem_rd_data = '0;
  logic          mem_busy;
  int            mem_t;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_busy       <= 1'b0;
      mem_data_ready <= 1'b0;
      mem_data_out   <= '0;
      mem_t          <= 0;
    end else begin
      if (mem_op_done) begin
        mem_data_ready <= 1'b0;
        mem_busy       <= 1'b0;
      end else if (mem_op_init) begin
        mem_busy     <= 1'b1;
        mem_t        <= 1;
        mem_data_out <= mem_rd_data;
        if (mem_delay == 2) mem_data_ready <= 1'b1;
      end else if (mem_busy && !mem_data_ready) begin
        mem_t <= mem_t + 1;
        if (mem_delay != 0 && mem_t + 1 == mem_delay - 1) mem_data_ready <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an op or a response.
  always @(negedge clk) begin
    op_t   eo;
    resp_t er;
    cyc = cyc + 1;
    if (reset_n) begin
      if (mem_op_done) begin
        n_done++;
        if (mem_data_ready) chk("enable_low_at_done", LW'(mem_enable), LW'(0));
      end
      if (mem_op_init) begin
        gap      = cyc - last_resp_cyc;
        init_cyc = cyc;
        if (exp_ops.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mem_op: got op=%0b addr=%h, required no op", mem_op, mem_address);
        end else begin
          eo = exp_ops.pop_front();
          chk("mem_op", LW'(mem_op), LW'(eo.op));
          chk("mem_address", LW'(mem_address), LW'(eo.addr));
          chk("mem_data_in", mem_data_in, eo.data);
          chk("mem_enable_at_init", LW'(mem_enable), LW'(1));
        end
      end
      if (resp_valid) begin
        last_resp_cyc = cyc;
        lat = cyc - init_cyc;
        if (exp_resp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got addr=%h err=%0b, required no response", resp_addr, resp_error);
        end else begin
          er = exp_resp.pop_front();
          chk("resp_data", resp_data, er.data);
          chk("resp_addr", LW'(resp_addr), LW'(er.addr));
          chk("resp_error", LW'(resp_error), LW'(er.err));
          chk("mem_enable_at_resp", LW'(mem_enable), LW'(0));
        end
      end
    end
  end

  task automatic send(input logic wb, input logic [AW-1:0] fa, input logic [AW-1:0] wa,
                      input logic [LW-1:0] wd);
    int c;
    @(negedge clk);
    req_wb        = wb;
    req_fill_addr = fa;
    req_wb_addr   = wa;
    req_wb_data   = wd;
    req_valid     = 1'b1;
    c = 0;
    while (!req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_ops.size() != 0 || exp_resp.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, LW'(c < budget), LW'(1));
    repeat (4) @(negedge clk);
  endtask

  localparam logic [LW-1:0] L1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [LW-1:0] L2  = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [LW-1:0] L3  = 128'h0F0F0F0F_F0F0F0F0_12121212_34343434;
  localparam logic [LW-1:0] L4  = 128'hCAFEBABE_00000001_00000002_00000003;
  localparam logic [LW-1:0] L5  = 128'h5555AAAA_6666BBBB_7777CCCC_8888DDDD;
  localparam logic [LW-1:0] A5  = {16{8'hA5}};
  localparam logic [LW-1:0] W3  = 128'h11112222_33334444_55556666_77778888;

  initial begin
    int d0;
    int c;
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_wb        = 1'b0;
    req_fill_addr = '0;
    req_wb_addr   = '0;
    req_wb_data   = '0;
    #12;
    chk("rst_req_ready", LW'(req_ready), LW'(1));
    chk("rst_mem_enable", LW'(mem_enable), LW'(0));
    chk("rst_resp_valid", LW'(resp_valid), LW'(0));
    chk("rst_mem_address", LW'(mem_address), LW'(0));
    chk("rst_resp_data", resp_data, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill only, 5-cycle memory.
    mem_delay = 5; mem_rd_data = L1; d0 = n_done;
    exp_ops.push_back('{op: 1'b0, addr: 12'h040, data: '0});
    exp_resp.push_back('{data: L1, addr: 12'h040, err: 1'b0});
    send(1'b0, 12'h040, 12'h000, '0);
    wait_idle("t1_complete", 200);
    chk("t1_latency", LW'(lat), LW'(7));
    chk("t1_done_count", LW'(n_done - d0), LW'(1));

    // Writeback then fill, unaligned victim address.
    mem_delay = 4; mem_rd_data = L2; d0 = n_done;
    exp_ops.push_back('{op: 1'b1, addr: 12'h1F0, data: A5});
    exp_ops.push_back('{op: 1'b0, addr: 12'h300, data: '0});
    exp_resp.push_back('{data: L2, addr: 12'h300, err: 1'b0});
    send(1'b1, 12'h300, 12'h1F7, A5);
    wait_idle("t2_complete", 200);
    chk("t2_done_count", LW'(n_done - d0), LW'(2));

    // Fill timeout, unaligned fill address.
    mem_delay = 0; mem_rd_data = L3; d0 = n_done;
    exp_ops.push_back('{op: 1'b0, addr: 12'h120, data: '0});
    exp_resp.push_back('{data: '0, addr: 12'h120, err: 1'b1});
    send(1'b0, 12'h123, 12'h000, '0);
    wait_idle("t3_complete", 200);
    chk("t3_latency", LW'(lat), LW'(TO));
    chk("t3_done_count", LW'(n_done - d0), LW'(1));

    // Writeback timeout: the fill must never be issued.
    mem_delay = 0; d0 = n_done;
    exp_ops.push_back('{op: 1'b1, addr: 12'h250, data: W3});
    exp_resp.push_back('{data: '0, addr: 12'h080, err: 1'b1});
    send(1'b1, 12'h080, 12'h255, W3);
    wait_idle("t4_complete", 200);
    repeat (10) @(negedge clk);
    chk("t4_done_count", LW'(n_done - d0), LW'(1));

    // Ready exactly at the timeout boundary counts as success.
    mem_delay = TO; mem_rd_data = L3;
    exp_ops.push_back('{op: 1'b0, addr: 12'h3C0, data: '0});
    exp_resp.push_back('{data: L3, addr: 12'h3C0, err: 1'b0});
    send(1'b0, 12'h3C0, 12'h000, '0);
    wait_idle("t5_complete", 200);
    chk("t5_latency", LW'(lat), LW'(TO + 2));

    // Reset during FILL_WAIT.
    mem_delay = 0; d0 = n_done;
    exp_ops.push_back('{op: 1'b0, addr: 12'h200, data: '0});
    send(1'b0, 12'h200, 12'h000, '0);
    repeat (5) @(negedge clk);
    chk("t6_enable_before_reset", LW'(mem_enable), LW'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_mem_enable", LW'(mem_enable), LW'(0));
    chk("t6_rst_mem_address", LW'(mem_address), LW'(0));
    chk("t6_rst_resp_addr", LW'(resp_addr), LW'(0));
    chk("t6_rst_req_ready", LW'(req_ready), LW'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("t6_no_done", LW'(n_done - d0), LW'(0));
    mem_delay = 3; mem_rd_data = L4;
    exp_ops.push_back('{op: 1'b0, addr: 12'h0C0, data: '0});
    exp_resp.push_back('{data: L4, addr: 12'h0C0, err: 1'b0});
    send(1'b0, 12'h0C0, 12'h000, '0);
    wait_idle("t6_complete", 200);
    chk("t6_latency", LW'(lat), LW'(5));

    // Request held while busy with a changed address.
    mem_delay = 4; mem_rd_data = L5;
    exp_ops.push_back('{op: 1'b0, addr: 12'h100, data: '0});
    exp_resp.push_back('{data: L5, addr: 12'h100, err: 1'b0});
    exp_ops.push_back('{op: 1'b0, addr: 12'h140, data: '0});
    exp_resp.push_back('{data: L5, addr: 12'h140, err: 1'b0});
    @(negedge clk);
    req_wb = 1'b0; req_fill_addr = 12'h100; req_valid = 1'b1;
    @(posedge clk);
    #1 req_fill_addr = 12'h140;
    @(negedge clk);
    c = 0;
    while (!req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle("t7_complete", 200);
    chk("t7_accept_gap", LW'(gap), LW'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
